toggle_stream_decoder: RTL and testbench



---
 rtl/toggle_pkg.sv | 12 +
 rtl/toggle_bit_decoder.sv | 26 ++
 rtl/toggle_stream_decoder.sv | 114 +++++++++++
 tb/tb_toggle_stream_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle-encoded stream receiver.
package toggle_pkg;

  localparam int DATA_W_DEF = 8;
  localparam logic [DATA_W_DEF-1:0] SYNC_WORD_DEF = 8'h7E;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_e;

endpackage

// File: rtl/toggle_bit_decoder.sv
// Recovers one bit per strobe from a toggle-encoded line by XOR against the previous sample.
module toggle_bit_decoder (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic line_in,
  output logic dec_bit,
  output logic bit_valid
);

  logic line_prev_q;
  logic line_prev_d;

  always_comb begin
    line_prev_d = en ? line_in : line_prev_q;
    dec_bit     = line_in ^ line_prev_q;
    bit_valid   = en;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) line_prev_q <= 1'b0;
    else          line_prev_q <= line_prev_d;
  end

endmodule

// File: rtl/toggle_stream_decoder.sv
// Sync-hunting deserialiser: aligns on SYNC_WORD, then emits MSB-first DATA_W-bit words.
module toggle_stream_decoder
  import toggle_pkg::*;
#(
  parameter int                CNT_W     = 8,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_WORD_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              line_in,
  input  logic              hunt,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              synced,
  output logic [CNT_W-1:0]  word_count
);

  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic dec_bit;
  logic bit_valid;

  toggle_bit_decoder u_bit_decoder (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .line_in   (line_in),
    .dec_bit   (dec_bit),
    .bit_valid (bit_valid)
  );

  state_e            state_q,      state_d;
  logic [DATA_W-1:0] sr_q,         sr_d;
  logic [BC_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              synced_q,     synced_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [DATA_W-1:0] shifted;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    word_count_d = word_count_q;
    shifted      = {sr_q[DATA_W-2:0], dec_bit};

    // hunt overrides any word completing on the same edge
    if (hunt) begin
      state_d   = HUNT;
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (bit_valid) begin
      sr_d = shifted;
      unique case (state_q)
        HUNT: begin
          if (shifted == SYNC_WORD) begin
            state_d      = DATA;
            bit_cnt_d    = '0;
            word_count_d = '0;
          end
        end
        DATA: begin
          if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (shifted == SYNC_WORD) begin
              word_count_d = '0;
            end else begin
              data_out_d   = shifted;
              data_valid_d = 1'b1;
              word_count_d = word_count_q + CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    synced_d = (state_d == DATA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      synced_q     <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      synced_q     <= synced_d;
      word_count_q <= word_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign synced     = synced_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_toggle_stream_decoder.sv
// Directed bench for toggle_stream_decoder: sync, data, gaps, re-sync, hunt abort, wrap, reset.
module tb_toggle_stream_decoder;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       line_in;
  logic       hunt;
  logic [7:0] data_out;
  logic       data_valid;
  logic       synced;
  logic [1:0] word_count;

  logic       line_lvl;
  int         pass_cnt;
  int         fail_cnt;
  int         total_cnt;

  toggle_stream_decoder #(
    .CNT_W     (2),
    .DATA_W    (8),
    .SYNC_WORD (8'h7E)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .line_in    (line_in),
    .hunt       (hunt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .synced     (synced),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one toggle-encoded bit and returns at the negedge after its sample edge.
  task automatic send_bit(input logic b, input int gap, input logic with_hunt);
    repeat (gap) @(negedge clk);
    en       = 1'b1;
    hunt     = with_hunt;
    line_lvl = line_lvl ^ b;
    line_in  = line_lvl;
    @(negedge clk);
    en   = 1'b0;
    hunt = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic gapped);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gapped ? (7 - i) % 4 : 0, 1'b0);
  endtask

  initial begin
    logic [7:0] wrap_words [5];
    logic [1:0] wrap_counts [5];
    logic [7:0] junk;

    pass_cnt  = 0;
    fail_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b1;
    en        = 1'b0;
    hunt      = 1'b0;
    line_in   = 1'b0;
    line_lvl  = 1'b0;

    // Asynchronous reset mid-cycle
    #3 reset_n = 1'b0;
    #1;
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_synced",     32'(synced),     32'h0);
    check("rst_word_count", 32'(word_count), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_synced", 32'(synced), 32'h0);

    // Sync acquisition: line 0,1,0,1,0,1,0,0
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h7E >> i), 0, 1'b0);
    check("sync_not_yet", 32'(synced), 32'h0);
    send_bit(1'b0, 0, 1'b0);
    check("sync_synced",     32'(synced),     32'h1);
    check("sync_word_count", 32'(word_count), 32'h0);
    check("sync_no_valid",   32'(data_valid), 32'h0);

    // Data word back-to-back
    send_word(8'hC3, 1'b0);
    check("c3_valid",      32'(data_valid), 32'h1);
    check("c3_data",       32'(data_out),   32'hC3);
    check("c3_word_count", 32'(word_count), 32'h1);
    @(negedge clk);
    check("c3_pulse_one_cycle", 32'(data_valid), 32'h0);
    check("c3_data_held",       32'(data_out),   32'hC3);

    // Data word with 0-3 idle cycles between strobes
    send_word(8'hA5, 1'b1);
    check("gap_valid",      32'(data_valid), 32'h1);
    check("gap_data",       32'(data_out),   32'hA5);
    check("gap_word_count", 32'(word_count), 32'h2);

    // Re-sync in DATA
    send_word(8'h7E, 1'b0);
    check("resync_no_valid",   32'(data_valid), 32'h0);
    check("resync_word_count", 32'(word_count), 32'h0);
    check("resync_synced",     32'(synced),     32'h1);
    check("resync_data_held",  32'(data_out),   32'hA5);

    send_word(8'h3C, 1'b0);
    check("3c_data",       32'(data_out),   32'h3C);
    check("3c_word_count", 32'(word_count), 32'h1);

    // Hunt on the same edge as the 8th bit of a word
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h81 >> i), 0, 1'b0);
    send_bit(1'b1, 0, 1'b1);
    check("abort_no_valid",   32'(data_valid), 32'h0);
    check("abort_synced",     32'(synced),     32'h0);
    check("abort_data_held",  32'(data_out),   32'h3C);
    check("abort_count_held", 32'(word_count), 32'h1);

    // Misaligned sync: 3 junk bits then the pattern
    junk = 8'b0000_0101;
    for (int i = 2; i >= 0; i--) send_bit(junk[i], 0, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h7E >> i), 0, 1'b0);
    check("misalign_not_yet", 32'(synced), 32'h0);
    send_bit(1'b0, 0, 1'b0);
    check("misalign_synced",     32'(synced),     32'h1);
    check("misalign_word_count", 32'(word_count), 32'h0);

    // Word counter wrap with a 2-bit counter
    wrap_words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wrap_counts = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      send_word(wrap_words[k], 1'b0);
      check($sformatf("wrap_data_%0d", k),  32'(data_out),   32'(wrap_words[k]));
      check($sformatf("wrap_count_%0d", k), 32'(word_count), 32'(wrap_counts[k]));
      check($sformatf("wrap_valid_%0d", k), 32'(data_valid), 32'h1);
    end

    // Reset asserted partway through a word
    for (int i = 7; i >= 4; i--) send_bit(1'(8'h96 >> i), 0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_data_out",   32'(data_out),   32'h00);
    check("midrst_synced",     32'(synced),     32'h0);
    check("midrst_word_count", 32'(word_count), 32'h0);
    line_lvl = 1'b0;
    line_in  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_word(8'h7E, 1'b0);
    check("midrst_resync", 32'(synced), 32'h1);
    send_word(8'hC3, 1'b0);
    check("midrst_data",       32'(data_out),   32'hC3);
    check("midrst_word_count", 32'(word_count), 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
